// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int STAGES_DEF = 5;

  localparam int IF  = 0;
  localparam int ID  = 1;
  localparam int EX  = 2;
  localparam int MEM = 3;
  localparam int WB  = 4;

endpackage

// File: rtl/pipe_valid_chain.sv
// Per-stage valid shift register with stall-hold, bubble-insert and flush controls.
module pipe_valid_chain
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = STAGES_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              shift_i,
  input  logic              in_i,
  input  logic              hold_lo_i,
  input  logic              bubble_i,
  input  logic              flush_i,
  output logic [STAGES-1:0] valid_o
);

  logic [STAGES-1:0] valid_q, valid_d;

  // Flush is applied last so it overrides both the hold and the shifted-in bit.
  always_comb begin
    valid_d = valid_q;
    if (shift_i) begin
      valid_d = {valid_q[STAGES-2:0], in_i};
      if (hold_lo_i) valid_d[ID:IF] = valid_q[ID:IF];
      if (bubble_i)  valid_d[EX]    = 1'b0;
      if (flush_i)   valid_d[ID:IF] = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) valid_q <= '0;
    else          valid_q <= valid_d;
  end

  assign valid_o = valid_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: fill, load-use bubble, branch flush and drain-to-idle.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = STAGES_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic              hazard,
  input  logic              flush,
  output logic              pc_en,
  output logic [STAGES-2:0] stage_en,
  output logic [STAGES-1:0] stage_valid,
  output logic              bubble,
  output logic              busy,
  output logic              done
);

  state_t state_q, state_d;
  logic   pending_q, pending_d;
  logic   stall;
  logic   drained;
  logic   pend_now;

  // A stall needs a real instruction in ID; a flush squashes it anyway.
  assign stall    = (state_q == RUN) && hazard && stage_valid[ID] && !flush;
  assign drained  = (state_q == DRAIN) && (stage_valid == '0);
  assign pend_now = pending_q || halt_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          pending_d = halt_req;
        end
      end
      RUN: begin
        pending_d = pend_now;
        if (stall)         state_d = STALL;
        else if (pend_now) state_d = DRAIN;
      end
      STALL: begin
        pending_d = pend_now;
        state_d   = pend_now ? DRAIN : RUN;
      end
      DRAIN: begin
        if (drained) begin
          state_d   = IDLE;
          pending_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_en    = 1'b0;
    stage_en = '0;
    bubble   = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: ;
      RUN, STALL: begin
        pc_en    = !stall;
        stage_en = '1;
        if (stall) stage_en[IF] = 1'b0;
        bubble   = stall;
      end
      DRAIN: begin
        stage_en = '1;
        done     = drained;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);

  pipe_valid_chain #(.STAGES(STAGES)) u_chain (
    .clk       (clk),
    .reset_n   (reset_n),
    .shift_i   ((state_q != IDLE) || start),
    .in_i      (state_q != DRAIN),
    .hold_lo_i (stall),
    .bubble_i  (stall),
    .flush_i   (flush && (state_q != IDLE)),
    .valid_o   (stage_valid)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a per-cycle behavioural model and literal spot checks.
module tb_pipe_ctrl;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         reset_n, start, halt_req, hazard, flush;
  logic         pc_en, bubble, busy, done;
  logic [N-2:0] stage_en;
  logic [N-1:0] stage_valid;

  int n_pass = 0;
  int n_total = 0;

  pipe_ctrl #(.STAGES(N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .halt_req(halt_req),
    .hazard(hazard), .flush(flush), .pc_en(pc_en), .stage_en(stage_en),
    .stage_valid(stage_valid), .bubble(bubble), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: mode, per-stage occupancy and the remembered halt.
  localparam int M_IDLE = 0, M_RUN = 1, M_STALL = 2, M_DRAIN = 3;
  int         md = M_IDLE, md_nx = M_IDLE;
  logic [N-1:0] mv = '0, mv_nx = '0;
  logic         pend = 1'b0, pend_nx = 1'b0;

  always @(negedge clk) begin
    logic [N-2:0] e_en;
    logic e_pc, e_bub, e_done, stalled;
    e_pc = 0; e_en = '0; e_bub = 0; e_done = 0; stalled = 0;
    mv_nx = mv; md_nx = md; pend_nx = pend;
    if (md == M_IDLE) begin
      if (start) begin
        mv_nx = 1; md_nx = M_RUN; pend_nx = halt_req;
      end
    end else begin
      // Every occupied stage moves one step down the pipe unless stated otherwise.
      for (int s = N - 1; s > 0; s--) mv_nx[s] = mv[s-1];
      if (md == M_DRAIN) begin
        mv_nx[0] = 0;
        e_en = '1;
        e_done = (mv == 0);
        if (e_done) begin md_nx = M_IDLE; pend_nx = 0; end
      end else begin
        stalled = (md == M_RUN) && hazard && mv[1] && !flush;
        pend_nx = pend || halt_req;
        e_pc = !stalled;
        e_en = '1;
        mv_nx[0] = 1;
        if (stalled) begin
          e_en[0] = 0; e_bub = 1;
          mv_nx[0] = mv[0]; mv_nx[1] = mv[1]; mv_nx[2] = 0;
          md_nx = M_STALL;
        end else md_nx = pend_nx ? M_DRAIN : M_RUN;
      end
      if (flush) begin mv_nx[0] = 0; mv_nx[1] = 0; end
    end
    chk("m_pc_en", pc_en, e_pc);
    chk("m_stage_en", stage_en, e_en);
    chk("m_stage_valid", stage_valid, mv);
    chk("m_bubble", bubble, e_bub);
    chk("m_busy", busy, md != M_IDLE);
    chk("m_done", done, e_done);
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin md <= M_IDLE; mv <= '0; pend <= 0; end
    else begin md <= md_nx; mv <= mv_nx; pend <= pend_nx; end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] fill_exp  [5] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111};
    logic [N-1:0] drain_exp [5] = '{5'b11110, 5'b11100, 5'b11000, 5'b10000, 5'b00000};
    int bubbles, dones, k;

    reset_n = 0; start = 0; halt_req = 0; hazard = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", stage_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pc_en", pc_en, 0);
    reset_n = 1;
    tick();

    // Fill
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 5; i++) begin
      chk("fill_valid", stage_valid, fill_exp[i]);
      if (i == 0) chk("fill_pc_en", pc_en, 1);
      if (i < 4) tick();
    end

    // Single hazard with full pipeline
    hazard = 1; #1;
    chk("haz_pc_en", pc_en, 0);
    chk("haz_stage_en", stage_en, 4'b1110);
    chk("haz_bubble", bubble, 1);
    tick(); hazard = 0; #1;
    chk("haz_valid1", stage_valid, 5'b11011);
    chk("haz_stall_pc", pc_en, 1);
    tick(); chk("haz_valid2", stage_valid, 5'b10111);
    tick(); chk("haz_valid3", stage_valid, 5'b01111);
    tick(); chk("haz_valid4", stage_valid, 5'b11111);

    // Hazard held for four cycles
    bubbles = 0;
    hazard = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bubble) bubbles++;
      tick();
    end
    hazard = 0;
    chk("hold_bubbles", bubbles, 2);
    chk("hold_valid", stage_valid, 5'b10111);
    tick(); tick();
    chk("hold_refill", stage_valid, 5'b11111);

    // Flush and hazard together
    hazard = 1; flush = 1; #1;
    chk("flh_bubble", bubble, 0);
    chk("flh_pc_en", pc_en, 1);
    chk("flh_stage_en", stage_en, 4'b1111);
    tick(); hazard = 0; flush = 0; #1;
    chk("flh_valid", stage_valid, 5'b11100);
    repeat (5) tick();
    chk("flh_refill", stage_valid, 5'b11111);

    // Halt from full RUN
    halt_req = 1; #1;
    chk("halt_run_pc", pc_en, 1);
    tick();
    chk("drain_pc", pc_en, 0);
    chk("drain_valid0", stage_valid, 5'b11111);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) dones++;
      tick();
      chk("drain_valid", stage_valid, drain_exp[i]);
    end
    chk("drain_done", done, 1);
    if (done) dones++;
    tick();
    halt_req = 0; #1;
    chk("drain_idle_busy", busy, 0);
    chk("drain_idle_done", done, 0);
    chk("drain_done_once", dones, 1);

    // start and halt together in IDLE
    start = 1; halt_req = 1;
    tick(); start = 0; #1;
    chk("sh_valid", stage_valid, 5'b00001);
    chk("sh_busy", busy, 1);
    k = 0;
    while (!done && k < 20) begin tick(); k++; end
    chk("sh_done", done, 1);
    tick(); halt_req = 0; #1;
    chk("sh_idle", busy, 0);

    // Reset in the middle of a drain
    start = 1; tick(); start = 0;
    repeat (4) tick();
    halt_req = 1;
    tick(); tick();
    chk("mid_valid", stage_valid, 5'b11110);
    #2 reset_n = 0; #1;
    chk("mid_rst_valid", stage_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    halt_req = 0;
    tick(); reset_n = 1;
    tick();
    start = 1; tick(); start = 0;
    chk("refill_valid0", stage_valid, 5'b00001);
    repeat (4) tick();
    chk("refill_valid4", stage_valid, 5'b11111);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage pipelined CPU. Owns the per-stage valid bits and generates the PC enable and the pipeline-register load enables that the datapath's stage registers consume each cycle. Handles start-up fill, single-cycle load-use bubbles, branch flush of the front end, and drain-to-idle on halt. Sits beside the hazard/forwarding logic and drives every stage-boundary register enable in the datapath.

## Interface
- STAGES, 5, number of pipeline stages (IF=0 … WB=STAGES-1); legal range 3..8
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin fetching; honoured only in IDLE
- halt_req  in  1  stop fetching and drain; level, held until done
- hazard  in  1  load-use hazard detected for instruction in ID
- flush  in  1  branch taken; squash IF and ID
- pc_en  out  1  PC register load enable
- stage_en  out  STAGES-1  stage_en[i] = load enable of register between stage i and i+1
- stage_valid  out  STAGES  registered valid bit of instruction in stage i
- bubble  out  1  bubble injected into stage 2 this cycle
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse: drain complete

## Operation
- States: IDLE, RUN, STALL, DRAIN. Reset: IDLE, stage_valid=0, pending-halt flag=0; combinationally pc_en=0, stage_en=0, bubble=0, busy=0, done=0.
- IDLE: all enables 0. start=1 → RUN, stage_valid<=…001.
- RUN (normal): pc_en=1, stage_en all 1; edge: v[0]<=1, v[i]<=v[i-1].
- RUN, hazard=1 and v[1]=1: pc_en=0, stage_en[0]=0, stage_en[1..]=1, bubble=1; edge: v[0],v[1] hold, v[2]<=0, v[i>2]<=v[i-1]; → STALL. hazard with v[1]=0 ignored.
- STALL: one cycle only; hazard ignored; behaves as RUN normal; → RUN.
- flush=1 (RUN, STALL, DRAIN): pc_en=1 (loads target; 0 in DRAIN), stage_en all 1, no bubble; edge: v[0]<=0, v[1]<=0, v[i≥2]<=v[i-1]. Priority flush > hazard.
- halt_req: latched into pending flag in RUN/STALL. Pending and not stalling this cycle → DRAIN on next edge (from STALL, after its single cycle).
- DRAIN: pc_en=0, stage_en all 1, v[0]<=0, shift. When v==0 at start of a cycle: done=1, → IDLE, pending cleared. Drain completes in ≤STAGES cycles.
- start outside IDLE ignored. start and halt_req together in IDLE: start wins, halt pending, drain begins next cycle.
- Reset mid-operation: immediate IDLE, all valids cleared, no done pulse.

## Timing
- stage_valid, state, pending: registered. pc_en, stage_en, bubble, done: combinational from state, valids, hazard, flush (Mealy).
- Fill latency: start at edge 0 → stage_valid=00001 after edge 0, 11111 after edge 4.
- Hazard cost: exactly one lost fetch per hazard; back-to-back hazards give at most one bubble per two cycles.
- Flush cost: two squashed slots; no stall.

## Structure
- Package pipe_ctrl_pkg: state enum (IDLE, RUN, STALL, DRAIN), STAGES default constant, stage index constants IF/ID/EX/MEM/WB.
- One sub-module: pipe_valid_chain — valid shift register with per-bit hold, clear-bit-2 (bubble) and clear-bits-0/1 (flush) controls. FSM, pending flag and enable decode stay in pipe_ctrl.

## Test plan
- Reset then start pulse → stage_valid 00001, 00011, …, 11111 on five successive cycles; pc_en=1 from first RUN cycle.
- hazard=1 for one cycle with pipeline full → that cycle pc_en=0, stage_en[0]=0, bubble=1; next cycle stage_valid[2]=0, then bubble propagates to WB and clears.
- hazard held high 4 cycles → bubbles on alternate cycles only (2 bubbles), STALL never consecutive.
- flush and hazard same cycle, full pipeline → no bubble, next stage_valid=11100.
- halt_req from full RUN → pc_en=0 next cycle, valids drain 11110, 11100, 11000, 10000, 00000, done pulses once, busy falls.
- reset_n asserted mid-DRAIN asynchronously → stage_valid=0, busy=0 immediately, no done pulse; later start refills normally.
